// File: rtl/ncl_seq_pkg.sv
// ----------------------------------------------------------------------------
// ncl_seq_pkg
// Shared types and helpers for the NCL address-enable sequencer.
//   seq_state_e   : controller states (IDLE, WAIT_D, WAIT_N, RECOVER)
//   TIMER_W       : width of the wavefront watchdog counter; sized for the
//                   largest legal TIMEOUT (255) so any legal value fits
//   dual_rail_enc : encodes one bit to a {true, false} rail pair; an
//                   invalid (NULL) bit yields 2'b00, never 2'b11
// ----------------------------------------------------------------------------
package ncl_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D  = 2'd1,
        WAIT_N  = 2'd2,
        RECOVER = 2'd3
    } seq_state_e;

    localparam int TIMEOUT_MAX = 255;
    localparam int TIMER_W     = $clog2(TIMEOUT_MAX + 1);

    function automatic logic [1:0] dual_rail_enc(input logic data, input logic valid);
        return {data & valid, ~data & valid};
    endfunction

endpackage

// File: rtl/ncl_addr_sequencer_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: searches req_i starting at rr_i+1 and
// wrapping modulo N_REQ; the first high request wins.
//   req_i   : request vector
//   rr_i    : index of the previous winner (search starts just after it)
//   gnt_o   : one-hot winner (all zero when nothing is requesting)
//   idx_o   : binary index of the winner
//   valid_o : at least one request is high
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] rr_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [$clog2(N_REQ)-1:0] idx_o,
    output logic                     valid_o
);
    localparam int IDX_W = $clog2(N_REQ);

    int cand;

    always_comb begin
        // NOTE: every output gets a default before the search loop so no path
        // through the block leaves a value unassigned (which would infer a latch).
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = (int'(rr_i) + i) % N_REQ;
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/ncl_addr_sequencer.sv
// ----------------------------------------------------------------------------
// ncl_addr_sequencer
// Sequences a dual-rail NCL address-enable stage: picks a requester
// round-robin, launches its address as a DATA wavefront (ph0 = DATA-true),
// waits for completion detect, launches NULL, waits for completion to return
// to NULL, then pulses done to the owner. A per-wavefront watchdog pulses err
// and parks in RECOVER until the stage reports NULL again.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-requester level request, held until done/err
//   addr       : requester i address at [i*ADDR_W +: ADDR_W]
//   cd         : asynchronous completion detect (1 = DATA, 0 = NULL)
//   a_t, a_f   : address true/false rails
//   ph0_t/f    : phase-0 true/false rails (ph0_f is never driven high)
//   grant      : one-hot owner of the current transaction
//   done, err  : one-cycle completion / timeout pulse to the owner
//   busy       : controller is not in IDLE
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module ncl_addr_sequencer
    import ncl_seq_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    input  logic                    cd,
    output logic [ADDR_W-1:0]       a_t,
    output logic [ADDR_W-1:0]       a_f,
    output logic                    ph0_t,
    output logic                    ph0_f,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        done,
    output logic [N_REQ-1:0]        err,
    output logic                    busy
);
    localparam int IDX_W = $clog2(N_REQ);

    seq_state_e         state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [N_REQ-1:0]   err_q, err_d;
    logic [ADDR_W-1:0]  a_t_q, a_t_d, a_f_q, a_f_d;
    logic               ph0_t_q, ph0_t_d, ph0_f_q, ph0_f_d;
    logic               busy_q;
    logic [TIMER_W-1:0] timer_q, timer_d, timer_inc;
    logic               timed_out;
    logic               load_data, load_null;
    logic               cd_meta_q, cd_s_q;

    logic [N_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic [ADDR_W-1:0]  win_addr, win_t, win_f;
    logic [1:0]         ph0_data;

    // cd is produced by the asynchronous NCL completion tree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cd_meta_q <= 1'b0;
            cd_s_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make both flops sample their
            // pre-edge values, giving a true two-stage shift.
            cd_meta_q <= cd;
            cd_s_q    <= cd_meta_q;
        end
    end

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_i   (req),
        .rr_i    (rr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // DATA encoding of the winner's address; only loaded on the grant edge,
    // so later addr changes never reach the rails.
    always_comb begin
        win_addr = addr[int'(arb_idx)*ADDR_W +: ADDR_W];
        win_t    = '0;
        win_f    = '0;
        for (int b = 0; b < ADDR_W; b++) begin
            {win_t[b], win_f[b]} = dual_rail_enc(win_addr[b], 1'b1);
        end
        ph0_data = dual_rail_enc(1'b1, 1'b1);
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        grant_d   = grant_q;
        done_d    = '0;
        err_d     = '0;
        timer_d   = timer_q;
        load_data = 1'b0;
        load_null = 1'b0;
        timer_inc = timer_q + TIMER_W'(1);
        // timer_q counts cycles already spent waiting, so the edge that would
        // make it TIMEOUT is the last one allowed.
        timed_out = (timer_inc == TIMER_W'(TIMEOUT));

        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d   = arb_gnt;
                    rr_d      = arb_idx;
                    load_data = 1'b1;
                    timer_d   = '0;
                    state_d   = WAIT_D;
                end
            end
            WAIT_D: begin
                if (cd_s_q) begin
                    load_null = 1'b1;
                    timer_d   = '0;
                    state_d   = WAIT_N;
                end else if (timed_out) begin
                    load_null = 1'b1;
                    err_d     = grant_q;
                    timer_d   = '0;
                    state_d   = RECOVER;
                end else begin
                    timer_d = timer_inc;
                end
            end
            WAIT_N: begin
                if (!cd_s_q) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    timer_d = '0;
                    state_d = IDLE;
                end else if (timed_out) begin
                    err_d   = grant_q;
                    timer_d = '0;
                    state_d = RECOVER;
                end else begin
                    timer_d = timer_inc;
                end
            end
            RECOVER: begin
                // No watchdog here: the stage must drain to NULL before any
                // new wavefront may be launched.
                if (!cd_s_q) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        a_t_d   = a_t_q;
        a_f_d   = a_f_q;
        ph0_t_d = ph0_t_q;
        ph0_f_d = ph0_f_q;
        if (load_data) begin
            a_t_d              = win_t;
            a_f_d              = win_f;
            {ph0_t_d, ph0_f_d} = ph0_data;
        end else if (load_null) begin
            a_t_d   = '0;
            a_f_d   = '0;
            ph0_t_d = 1'b0;
            ph0_f_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= IDX_W'(N_REQ - 1);
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            a_t_q   <= '0;
            a_f_q   <= '0;
            ph0_t_q <= 1'b0;
            ph0_f_q <= 1'b0;
            busy_q  <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            a_t_q   <= a_t_d;
            a_f_q   <= a_f_d;
            ph0_t_q <= ph0_t_d;
            ph0_f_q <= ph0_f_d;
            busy_q  <= (state_d != IDLE);
            timer_q <= timer_d;
        end
    end

    assign a_t   = a_t_q;
    assign a_f   = a_f_q;
    assign ph0_t = ph0_t_q;
    assign ph0_f = ph0_f_q;
    assign grant = grant_q;
    assign done  = done_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: doc/ncl_addr_sequencer.md
Name: ncl_addr_sequencer

Overview:
- Clocked controller that sequences the dual-rail NCL address-enable stage.
- Arbitrates round-robin among N_REQ synchronous requesters and encodes the winner's binary address to dual-rail.
- Drives the DATA wavefront (PH0 = DATA-true), waits for downstream completion detection, then drives the NULL wavefront and waits for completion to return to NULL.
- Provides per-requester done/err pulses; a watchdog recovers from a stalled wavefront.

Parameters:
N_REQ, 2, number of requesters (2..8)
ADDR_W, 4, address width in bits
TIMEOUT, 15, max clk cycles spent waiting for completion per wavefront (1..255)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester request, level, held until done or err
addr  in  N_REQ*ADDR_W  requester i address at bits [i*ADDR_W +: ADDR_W]
cd  in  1  completion detect from NCL stage: 1 = all outputs DATA, 0 = all NULL (asynchronous)
a_t  out  ADDR_W  address true rails
a_f  out  ADDR_W  address false rails
ph0_t  out  1  phase-0 true rail
ph0_f  out  1  phase-0 false rail
grant  out  N_REQ  one-hot owner of the current transaction
done  out  N_REQ  one-cycle pulse to the owner on successful completion
err  out  N_REQ  one-cycle pulse to the owner on timeout
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE; all rails, grant, done, err and busy = 0; rr pointer = N_REQ-1; synchronizer = 0; timer = 0.
- All outputs are registered; no combinational path from inputs to outputs.
- cd passes through a 2-flop synchronizer (cd_s) before the FSM uses it.
- Dual-rail rule: in DATA, a_t = latched addr, a_f = ~latched addr, ph0_t = 1, ph0_f = 0. In NULL, all rails = 0. No rail pair is ever 1/1. ph0_f is never driven 1.
- IDLE:
  - If any req is high, choose the first high req searching from rr+1 with modulo wrap.
  - On the same edge: set grant one-hot, latch that requester's addr, drive DATA rails, update rr = winner, go to WAIT_D.
  - Rails are therefore valid 1 cycle after req is first sampled.
- WAIT_D:
  - cd_s = 1 -> drive NULL rails, clear timer, go to WAIT_N.
  - Timer reaches TIMEOUT -> drive NULL rails, pulse err[owner], go to RECOVER.
- WAIT_N:
  - cd_s = 0 -> pulse done[owner], clear grant, go to IDLE.
  - Timer reaches TIMEOUT -> pulse err[owner], go to RECOVER.
- RECOVER:
  - Rails held NULL; clear grant once cd_s = 0, then go to IDLE.
  - RECOVER has no timeout; busy stays high.
- Timer: increments every cycle in WAIT_D and WAIT_N; cleared on each state change.
- Latency with an ideal NCL stage (cd tracks rails immediately): req sampled at edge 0; DATA rails from edge 1; NULL from edge 4; done pulse and grant cleared at edge 7; a new grant is possible at edge 8.
- Input changes after grant:
  - addr and req changes are ignored until the transaction ends.
  - A dropped req does not abort the transaction; done still pulses.
- A held req is eligible again in IDLE, subject to the rr pointer.
- done and err are mutually exclusive; at most one bit of either is set.
- Reset mid-transaction: rails go NULL immediately (async); no done/err is issued.

Decomposition:
- Package ncl_seq_pkg holds:
  - state enum {IDLE, WAIT_D, WAIT_N, RECOVER};
  - localparam TIMER_W = $clog2(TIMEOUT+1);
  - a function dual_rail_enc(data, valid) returning {t, f}.
- Sub-module rr_arbiter (N_REQ): combinational round-robin pick from req and rr pointer; returns a one-hot winner and its index.
- The 2-flop synchronizer is instantiated inline.

Test Plan:
1. ADDR_W=4; req=01, addr0=4'hA; cd follows ph0_t with 2-cycle delay -> a_t=1010, a_f=0101, ph0_t=1 one cycle after req; grant=01; after cd rises, all rails 0; after cd falls, done=01 for exactly one cycle, busy=0.
2. req=11 held continuously from reset -> grants alternate 01,10,01,10; each grant preceded by done to the previous owner; never two bits of grant set.
3. req=10, cd tied 0, TIMEOUT=15 -> rails NULL and err=10 exactly 15 cycles after entering WAIT_D; done never pulses; state returns to IDLE after RECOVER.
4. cd stuck 1 after DATA -> err pulses TIMEOUT cycles into WAIT_N; state holds RECOVER, busy=1, until cd=0; then IDLE.
5. During WAIT_D, change addr0 from A to 5 and drop req0 -> rails stay 1010/0101; done still pulses to requester 0.
6. Assert rst_n=0 in WAIT_D -> all rails, grant and busy are 0 without waiting for a clk edge; after release, the first grant goes to req0 when req=11.
